card_deal_arbiter: RTL and testbench

Shares the single free-running card RNG between the player and dealer requesters, and tracks shoe depletion per rank. It sits between the RNG and the game FSM. Each request event yields exactly one dealt card, tagged with its destination. Out-of-range or exhausted RNG draws are rejected, and a bounded fallback scan guarantees forward progress.

---
 rtl/card_deal_arbiter_pkg.sv | 12 +
 rtl/card_deal_arbiter_shoe_counter.sv | 46 ++++
 rtl/card_deal_arbiter.sv | 121 ++++++++++++
 tb/tb_card_deal_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/card_deal_arbiter_pkg.sv
// bj_pkg: shared card types, rank bounds, rank-to-value mapping and deal FSM states.
package bj_pkg;
  typedef logic [3:0] rank_t;
  typedef logic [3:0] value_t;
  typedef enum logic {DEST_PLAYER = 1'b0, DEST_DEALER = 1'b1} dest_t;
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_SCAN, S_ISSUE} deal_state_t;
  localparam rank_t RANK_MIN = 4'd1;
  localparam rank_t RANK_MAX = 4'd13;
  function automatic value_t rank_to_value(input rank_t r);
    return (r > 4'd10) ? 4'd10 : r;
  endfunction
endpackage

// File: rtl/card_deal_arbiter_shoe_counter.sv
// shoe_counter: per-rank shoe counts, cards_left, and lowest-nonzero-rank encoder.
// Slots 0, 14 and 15 stay at zero, so out-of-range queries read as unavailable.
module shoe_counter
  import bj_pkg::*;
#(
  parameter int DECKS = 1,
  localparam int CLW = $clog2(52 * DECKS + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           reload_i,
  input  logic           dec_i,
  input  rank_t          dec_rank_i,
  input  rank_t          query_i,
  output logic           query_ok_o,
  output logic [CLW-1:0] cards_left_o,
  output rank_t          low_rank_o,
  output logic           found_o
);
  localparam logic [4:0] FULL = 5'(4 * DECKS);
  localparam logic [CLW-1:0] FULL_LEFT = CLW'(52 * DECKS);
  logic [4:0] cnt_q [16];
  logic [CLW-1:0] left_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) cnt_q[i] <= (i >= 1 && i <= 13) ? FULL : 5'd0;
      left_q <= FULL_LEFT;
    end else if (reload_i) begin
      for (int i = 0; i < 16; i++) cnt_q[i] <= (i >= 1 && i <= 13) ? FULL : 5'd0;
      left_q <= FULL_LEFT;
    end else if (dec_i && cnt_q[dec_rank_i] != 5'd0) begin
      cnt_q[dec_rank_i] <= cnt_q[dec_rank_i] - 5'd1;
      left_q <= left_q - 1'b1;
    end
  always_comb begin
    low_rank_o = '0;
    found_o = 1'b0;
    for (int i = 13; i >= 1; i--)
      if (cnt_q[i] != 5'd0) begin
        low_rank_o = rank_t'(i);
        found_o = 1'b1;
      end
  end
  assign query_ok_o = cnt_q[query_i] != 5'd0;
  assign cards_left_o = left_q;
endmodule

// File: rtl/card_deal_arbiter.sv
// card_deal_arbiter: shares the card RNG between player and dealer, one card per request edge.
// DECK_TRACK_EN enables per-rank shoe depletion; undefined models an infinite shoe.
module card_deal_arbiter
  import bj_pkg::*;
#(
  parameter int DECKS = 1,
  parameter int MAX_RETRY = 16,
  parameter int RESHUFFLE_THRESH = 15,
  localparam int CLW = $clog2(52 * DECKS + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     rng_rank,
  input  logic           player_req,
  input  logic           dealer_req,
  input  logic           new_round,
  output logic           card_valid,
  output logic           card_dest,
  output logic [3:0]     card_rank,
  output logic [3:0]     card_value,
  output logic [CLW-1:0] cards_left,
  output logic           shoe_empty,
  output logic           shuffle_pending,
  output logic           busy
);
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RW-1:0] RLAST = RW'(MAX_RETRY - 1);
  deal_state_t state_q, state_d;
  dest_t last_q, last_d, grant_q, grant_d, pick;
  logic [1:0] req_q, pend_q, pend_d, clr;
  logic [RW-1:0] retry_q, retry_d;
  rank_t rank_q, rank_d, scan_rank;
  logic reload, dec, draw_ok;
`ifdef DECK_TRACK_EN
  localparam bit TRACK = 1'b1;
  logic query_ok, found;
  rank_t low_rank;
  shoe_counter #(.DECKS(DECKS)) u_shoe (
    .clk(clk), .rst_n(rst_n), .reload_i(reload), .dec_i(dec), .dec_rank_i(rank_q),
    .query_i(rng_rank), .query_ok_o(query_ok), .cards_left_o(cards_left),
    .low_rank_o(low_rank), .found_o(found)
  );
  assign draw_ok = query_ok;
  assign scan_rank = found ? low_rank : RANK_MIN;
  assign shoe_empty = cards_left == '0;
  assign shuffle_pending = cards_left < CLW'(RESHUFFLE_THRESH);
`else
  localparam bit TRACK = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{reload, dec, new_round};
  assign draw_ok = rng_rank >= RANK_MIN && rng_rank <= RANK_MAX;
  assign scan_rank = RANK_MIN;
  assign cards_left = CLW'(52 * DECKS);
  assign shoe_empty = 1'b0;
  assign shuffle_pending = 1'b0;
`endif
  // On a tie the requester not served last wins.
  assign pick = (pend_q == 2'b11) ? ((last_q == DEST_PLAYER) ? DEST_DEALER : DEST_PLAYER)
                                  : (pend_q[1] ? DEST_DEALER : DEST_PLAYER);
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    retry_d = retry_q;
    rank_d = rank_q;
    last_d = last_q;
    reload = 1'b0;
    dec = 1'b0;
    clr = 2'b00;
    case (state_q)
      S_IDLE:
        if (TRACK && new_round) reload = 1'b1;
        else if (|pend_q && !shoe_empty) begin
          grant_d = pick;
          retry_d = '0;
          state_d = S_DRAW;
        end
      S_DRAW:
        if (draw_ok) begin
          rank_d = rng_rank;
          state_d = S_ISSUE;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_q == RLAST) ? S_SCAN : S_DRAW;
        end
      S_SCAN: begin
        rank_d = scan_rank;
        state_d = S_ISSUE;
      end
      default: begin
        dec = 1'b1;
        last_d = grant_q;
        clr = (grant_q == DEST_DEALER) ? 2'b10 : 2'b01;
        state_d = S_IDLE;
      end
    endcase
  end
  assign pend_d = (pend_q | ({dealer_req, player_req} & ~req_q)) & ~clr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q <= 2'b00;
      pend_q <= 2'b00;
      last_q <= DEST_DEALER;
      grant_q <= DEST_PLAYER;
      retry_q <= '0;
      rank_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= {dealer_req, player_req};
      pend_q <= pend_d;
      last_q <= last_d;
      grant_q <= grant_d;
      retry_q <= retry_d;
      rank_q <= rank_d;
    end
  assign card_valid = state_q == S_ISSUE;
  assign card_dest = grant_q;
  assign card_rank = rank_q;
  assign card_value = rank_to_value(rank_q);
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_card_deal_arbiter.sv
// tb_card_deal_arbiter: scoreboard bench for card_deal_arbiter (DECKS=1), both DECK_TRACK_EN builds.
module tb_card_deal_arbiter;
`ifdef DECK_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] rng_rank = 4'd0;
  logic player_req = 1'b0, dealer_req = 1'b0, new_round = 1'b0;
  logic card_valid, card_dest, shoe_empty, shuffle_pending, busy;
  logic [3:0] card_rank, card_value;
  logic [5:0] cards_left;
  int cyc = 0, errs = 0, checks = 0, left_m = 52;
  typedef struct {logic dest; logic [3:0] rank; int cyc;} exp_t;
  exp_t sb[$];

  card_deal_arbiter #(.DECKS(1), .MAX_RETRY(16), .RESHUFFLE_THRESH(15)) dut (
    .clk(clk), .rst_n(rst_n), .rng_rank(rng_rank), .player_req(player_req),
    .dealer_req(dealer_req), .new_round(new_round), .card_valid(card_valid),
    .card_dest(card_dest), .card_rank(card_rank), .card_value(card_value),
    .cards_left(cards_left), .shoe_empty(shoe_empty), .shuffle_pending(shuffle_pending),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int val_of(input int r);
    return (r >= 10) ? 10 : r;
  endfunction

  always @(negedge clk)
    if (rst_n && card_valid) begin
      if (sb.size() == 0) check("unexpected_card", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("dest", card_dest, e.dest);
        check("rank", card_rank, e.rank);
        check("value", card_value, val_of(e.rank));
        check("latency_cycle", cyc, e.cyc);
      end
    end

  task automatic expect_card(input logic d, input logic [3:0] r, input int lat);
    sb.push_back('{d, r, cyc + lat});
  endtask

  task automatic rise(input logic p, input logic d);
    @(posedge clk); #1;
    player_req = p;
    dealer_req = d;
  endtask

  task automatic drain(input int budget);
    @(posedge clk); #1;
    player_req = 1'b0;
    dealer_req = 1'b0;
    for (int i = 0; i < budget && sb.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    left_m = 52;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_left", cards_left, 52);
    check("rst_valid", card_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_shuffle", shuffle_pending, 0);
    check("rst_empty", shoe_empty, 0);
    check("rst_rank", card_rank, 0);
    check("rst_value", card_value, 0);
    // single player card, minimum latency
    rng_rank = 4'd5;
    rise(1, 0); expect_card(0, 5, 3); drain(10);
    left_m -= TRACK ? 1 : 0;
    check("left_after_one", cards_left, left_m);
    // simultaneous requests after reset: player wins the first tie
    do_reset();
    rise(1, 1); expect_card(0, 5, 3); expect_card(1, 5, 6); drain(20);
    left_m -= TRACK ? 2 : 0;
    check("left_after_tie", cards_left, left_m);
    // illegal RNG forces the scan fallback
    rng_rank = 4'd14;
    rise(0, 1); expect_card(1, 1, 19); drain(40);
    left_m -= TRACK ? 1 : 0;
    check("left_after_scan", cards_left, left_m);
    // exhaust rank 7
    rng_rank = 4'd7;
    for (int i = 0; i < 4; i++) begin
      rise(1, 0); expect_card(0, 7, 3); drain(10);
    end
    rise(1, 0); expect_card(0, TRACK ? 4'd1 : 4'd7, TRACK ? 19 : 3); drain(40);
    left_m -= TRACK ? 5 : 0;
    check("left_after_rank7", cards_left, left_m);
    // last grant was player, so dealer wins this tie
    rng_rank = 4'd3;
    rise(1, 1); expect_card(1, 3, 3); expect_card(0, 3, 6); drain(20);
    left_m -= TRACK ? 2 : 0;
    check("left_after_alt", cards_left, left_m);
    // async reset mid-draw issues no card and changes no count
    rng_rank = 4'd14;
    rise(1, 0);
    @(posedge clk); #1 player_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("busy_mid_draw", busy, 1);
    do_reset();
    check("abort_busy", busy, 0);
    check("abort_left", cards_left, 52);
    repeat (20) @(posedge clk);
    #1 check("abort_no_card", busy, 0);
    // drain the shoe one card at a time, never rejecting a draw
    for (int i = 0; i < 52; i++) begin
      rng_rank = 4'((i % 13) + 1);
      rise(1, 0); expect_card(0, rng_rank, 3); drain(10);
      left_m -= TRACK ? 1 : 0;
      check("drain_left", cards_left, left_m);
      check("drain_shuffle", shuffle_pending, TRACK && left_m < 15);
      check("drain_empty", shoe_empty, TRACK && left_m == 0);
    end
    rng_rank = 4'd9;
`ifdef DECK_TRACK_EN
    rise(1, 0);
    @(posedge clk); #1 player_req = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("empty_busy", busy, 0);
    check("empty_flag", shoe_empty, 1);
    check("empty_left", cards_left, 0);
    @(posedge clk); #1 new_round = 1'b1;
    expect_card(0, 9, 3);
    @(posedge clk); #1 new_round = 1'b0;
    check("reload_left", cards_left, 52);
    drain(10);
    check("left_after_reload", cards_left, 51);
`else
    rise(1, 0); expect_card(0, 9, 3); drain(10);
    @(posedge clk); #1 new_round = 1'b1;
    @(posedge clk); #1 new_round = 1'b0;
    check("inf_left", cards_left, 52);
    check("inf_busy", busy, 0);
`endif
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
